// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID decoupling queue and its neighbours in the pipeline.
// Holds the default PC width and the NOP encoding shown to ID when the queue is empty.
package if_id_queue_pkg;

    localparam int unsigned ADDR_WIDTH = 32;

    // NOP encoding; the hazard unit uses the same value when it inserts bubbles.
    localparam logic [31:0] IF_ID_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for if_id_queue: DEPTH x WIDTH register array.
// Has one write port on the falling edge and one asynchronous read port.
module if_id_queue_mem #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clock,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] entries [DEPTH];

    // Contents are deliberately not reset; the pointers and count define what is valid.
    always_ff @(negedge i_clock) begin
        if (i_wr_en) begin
            entries[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = entries[i_rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Decoupling queue between the fetch and decode stages, carrying {pc, instruction} pairs.
// Provides a valid/ready handshake on both sides, a flush input and an occupancy count.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = ADDR_WIDTH,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NB_ADDR-1:0]       i_pc,
    input  logic [NB_DATA-1:0]       i_instruction,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NB_ADDR-1:0]       o_pc,
    output logic [NB_DATA-1:0]       o_instruction,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = NB_ADDR + NB_DATA;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               push;
    logic               pop;
    logic               mem_wr_en;
    logic [ENTRY_W-1:0] head;

    // Ready comes only from the registered count, so a full queue refuses a push
    // even when the head is being popped in the same cycle.
    assign o_ready = (count != FULL_COUNT);
    assign o_valid = (count != '0);
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(negedge i_clock) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    // A push squashed by flush or reset must not land in storage.
    assign mem_wr_en = push & ~i_flush & i_reset;

    if_id_queue_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clock   (i_clock),
        .i_wr_en   (mem_wr_en),
        .i_wr_addr (wr_ptr),
        .i_wr_data ({i_pc, i_instruction}),
        .i_rd_addr (rd_ptr),
        .o_rd_data (head)
    );

    assign o_pc          = o_valid ? head[ENTRY_W-1 -: NB_ADDR] : '0;
    assign o_instruction = o_valid ? head[NB_DATA-1:0] : NB_DATA'(IF_ID_BUBBLE);
    assign o_count       = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus queues expected pops, a monitor checks them.
// Inputs change just after the falling (active) edge; the monitor samples on the rising edge.
module tb_if_id_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_ADDR = 32;

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_flush;
    logic               i_valid;
    logic               o_ready;
    logic [NB_ADDR-1:0] i_pc;
    logic [NB_DATA-1:0] i_instruction;
    logic               o_valid;
    logic               i_ready;
    logic [NB_ADDR-1:0] o_pc;
    logic [NB_DATA-1:0] o_instruction;
    logic [2:0]         o_count;

    int          checks    = 0;
    int          errors    = 0;
    int          exp_count = 0;
    bit          mon_en    = 1'b0;
    logic [63:0] sb [$];

    if_id_queue #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_pc          (i_pc),
        .i_instruction (i_instruction),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_pc          (o_pc),
        .o_instruction (o_instruction),
        .o_count       (o_count)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'h1300_0000 | pc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the reference occupancy follows the active edge.
    task automatic step(input bit v, input logic [31:0] pc, input bit rdy, input bit fl,
                        input bit rst);
        bit acc;
        bit pp;
        i_valid       = v;
        i_pc          = pc;
        i_instruction = ins(pc);
        i_ready       = rdy;
        i_flush       = fl;
        i_reset       = rst;
        acc = v && (exp_count != DEPTH) && !fl && rst;
        pp  = rdy && (exp_count != 0);
        if (acc) sb.push_back({pc, ins(pc)});
        @(negedge i_clock);
        #1;
        if (!rst || fl) begin
            exp_count = 0;
            sb.delete();
        end else begin
            exp_count = exp_count + int'(acc) - int'(pp);
        end
    endtask

    initial begin
        logic [63:0] exp;
        forever begin
            @(posedge i_clock);
            if (mon_en) begin
                chk("count", {61'd0, o_count}, 64'(exp_count));
                chk("valid", {63'd0, o_valid}, {63'd0, exp_count != 0});
                chk("ready", {63'd0, o_ready}, {63'd0, exp_count != DEPTH});
                if (exp_count == 0) begin
                    chk("empty_pc", {32'd0, o_pc}, 64'd0);
                    chk("empty_instr", {32'd0, o_instruction}, 64'd0);
                end else if (i_ready && !i_flush && i_reset) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got pc 0x%0h, expected no pop", o_pc);
                    end else begin
                        exp = sb.pop_front();
                        chk("pop_pc", {32'd0, o_pc}, {32'd0, exp[63:32]});
                        chk("pop_instr", {32'd0, o_instruction}, {32'd0, exp[31:0]});
                    end
                end
            end
        end
    end

    initial begin
        i_reset       = 1'b0;
        i_flush       = 1'b0;
        i_valid       = 1'b0;
        i_ready       = 1'b0;
        i_pc          = '0;
        i_instruction = '0;

        // Reset held for two edges with a valid fetch present.
        step(1, 32'h100, 0, 0, 0);
        step(1, 32'h100, 0, 0, 0);
        chk("rst_count", {61'd0, o_count}, 64'd0);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_pc", {32'd0, o_pc}, 64'd0);
        chk("rst_instr", {32'd0, o_instruction}, 64'd0);
        mon_en = 1'b1;

        // Fill with decode stalled, attempt an overflow, then drain in order.
        for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 0, 1);
        chk("fill_count", {61'd0, o_count}, 64'd4);
        chk("fill_ready", {63'd0, o_ready}, 64'd0);
        step(1, 32'h10, 0, 0, 1);
        chk("overflow_count", {61'd0, o_count}, 64'd4);
        chk("overflow_head", {32'd0, o_pc}, 64'h0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 1);
        chk("drain_valid", {63'd0, o_valid}, 64'd0);

        // Full queue with a simultaneous pop: only the pop happens.
        for (int i = 0; i < 4; i++) step(1, 32'h20 + 32'(i * 4), 0, 0, 1);
        step(1, 32'h30, 1, 0, 1);
        chk("fullpop_count", {61'd0, o_count}, 64'd3);
        step(1, 32'h30, 1, 0, 1);
        chk("refill_count", {61'd0, o_count}, 64'd3);
        chk("refill_head", {32'd0, o_pc}, 64'h28);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0, 1);

        // Streaming one push and one pop per cycle; pointers wrap several times.
        for (int i = 0; i < 16; i++) begin
            step(1, 32'h200 + 32'(i * 4), 1, 0, 1);
            chk("stream_count", {61'd0, o_count}, 64'd1);
        end
        step(0, 32'h0, 1, 0, 1);

        // Flush with a concurrent push: 0x40 must never surface.
        step(1, 32'h300, 0, 0, 1);
        step(1, 32'h304, 0, 0, 1);
        chk("preflush_count", {61'd0, o_count}, 64'd2);
        step(1, 32'h40, 0, 1, 1);
        chk("flush_count", {61'd0, o_count}, 64'd0);
        chk("flush_valid", {63'd0, o_valid}, 64'd0);
        chk("flush_ready", {63'd0, o_ready}, 64'd1);
        chk("flush_instr", {32'd0, o_instruction}, 64'd0);
        step(1, 32'h44, 0, 0, 1);
        chk("postflush_count", {61'd0, o_count}, 64'd1);
        chk("postflush_pc", {32'd0, o_pc}, 64'h44);
        step(0, 32'h0, 1, 0, 1);

        // Reset mid-stream discards everything; 0x80 becomes the first entry.
        for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i * 4), 0, 0, 1);
        chk("prereset_count", {61'd0, o_count}, 64'd3);
        step(0, 32'h0, 0, 0, 0);
        chk("midrst_count", {61'd0, o_count}, 64'd0);
        chk("midrst_valid", {63'd0, o_valid}, 64'd0);
        chk("midrst_ready", {63'd0, o_ready}, 64'd1);
        chk("midrst_pc", {32'd0, o_pc}, 64'd0);
        chk("midrst_instr", {32'd0, o_instruction}, 64'd0);
        step(1, 32'h80, 0, 0, 1);
        chk("postrst_pc", {32'd0, o_pc}, 64'h80);
        chk("postrst_instr", {32'd0, o_instruction}, 64'h1300_0080);
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 0, 0, 1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised successor to the IF/ID pipeline latch: a DEPTH-entry decoupling queue between the fetch and decode stages carrying {pc, instruction} pairs. It adds a valid/ready handshake on both sides, branch/exception flush, and occupancy reporting, so fetch can run ahead of a stalled decode without losing instructions. It sits directly between the IF stage outputs and the ID stage inputs.

## Interface

Parameters:
- NB_DATA, 32, instruction width
- NB_ADDR, `ADDRWIDTH, PC width
- DEPTH, 4, number of entries; power of two, ≥ 2

Ports:
- i_clock  in  1  stage clock; all state updates on the falling edge, as in the rest of the pipeline latches
- i_reset  in  1  reset, synchronous, active-low; sampled on the active clock edge
- i_flush  in  1  squash all queued entries (taken branch / jump / exception)
- i_valid  in  1  IF presents a valid {i_pc, i_instruction}
- o_ready  out  1  queue can accept a push this cycle
- i_pc  in  NB_ADDR  PC of fetched instruction
- i_instruction  in  NB_DATA  fetched instruction
- o_valid  out  1  head entry valid for ID
- i_ready  in  1  ID accepts head this cycle (not stalled)
- o_pc  out  NB_ADDR  head PC; 0 when empty
- o_instruction  out  NB_DATA  head instruction; `IF_ID_BUBBLE when empty
- o_count  out  $clog2(DEPTH)+1  current occupancy

## Operation

- Storage: circular buffer, write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH; count register $clog2(DEPTH)+1 bits, range 0..DEPTH.
- push = i_valid & o_ready; pop = o_valid & i_ready.
- o_ready = (count != DEPTH). Derived from registered count only; never from i_ready. Push is therefore refused when full even if a pop occurs in the same cycle.
- o_valid = (count != 0).
- Push: write entry at wr_ptr, wr_ptr+1. Pop: rd_ptr+1. Push & pop together: both pointers advance, count unchanged.
- count next: +1 on push only, −1 on pop only, unchanged otherwise.
- Outputs: o_pc/o_instruction = entry[rd_ptr] when o_valid, else 0 / `IF_ID_BUBBLE (NOP bubble into ID).
- No bypass: an entry pushed into an empty queue is not visible on outputs in the same cycle.
- Flush: on the active edge with i_flush=1, wr_ptr=rd_ptr=0 and count=0. A push presented in the same cycle is discarded. A pop in the same cycle is irrelevant. Flush overrides push and pop.
- i_valid while o_ready=0: input ignored; IF must hold it (handshake rule: IF keeps i_pc/i_instruction stable while i_valid & !o_ready).
- Priority on each edge: reset > flush > push/pop.

## Timing

- Reset (i_reset=0 at active edge): wr_ptr=rd_ptr=count=0 → o_valid=0, o_ready=1, o_count=0, o_pc=0, o_instruction=`IF_ID_BUBBLE. Storage contents not reset. Reset asserted mid-operation discards all entries on that edge.
- Latency: push on edge k → o_valid=1 and data on outputs from edge k onward (one edge, minimum).
- Throughput: 1 push and 1 pop per cycle while 0 < count < DEPTH.
- Full: after DEPTH pushes with no pop, o_ready=0. The first pop edge restores o_ready=1; a push is accepted from the next edge.
- Flush: o_valid=0 and o_ready=1 immediately after the flush edge; a new push is accepted on the following edge.

## Structure

- parameters.vh (shared): `ADDRWIDTH (existing); add `IF_ID_BUBBLE (NB_DATA'h0, the NOP encoding) for use by this block and the hazard unit.
- One sub-module: if_id_queue_mem, a DEPTH×(NB_ADDR+NB_DATA) register array with one write port (en, addr, data) on the falling edge and one asynchronous read port. Pointer, count, flush and handshake logic stay in the top.

## Test plan

- Reset: hold i_reset=0 for 2 edges with i_valid=1 → o_valid=0, o_ready=1, o_count=0, o_pc=0, o_instruction=0.
- Fill/drain, DEPTH=4, i_ready=0: push pc 0x00, 0x04, 0x08, 0x0C → o_count=4, o_ready=0. A fifth push of 0x10 is ignored. Then i_ready=1 → pcs 0x00, 0x04, 0x08, 0x0C pop in order, then o_valid=0.
- Streaming: i_valid=i_ready=1 for 16 cycles with incrementing pc → o_count stays 1 after the first edge and the output pc sequence is identical to the input; wrap-around of both pointers exercised.
- Full + simultaneous pop: count=4, i_valid=1, i_ready=1 → one pop only, o_count=3. The push is accepted on the next edge → o_count stays 3 with one push and one pop.
- Flush with push: count=2, i_flush=1, i_valid=1 (pc 0x40) → next edge o_count=0, o_valid=0, o_instruction=0. Pc 0x40 never appears.
- Reset mid-stream: count=3, drive i_reset=0 for one edge → all outputs at reset values. The next push of pc 0x80 is the first entry popped.
